// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Arbitrates the single data-memory port between the pipeline MEM stage and
// the debug/loader port, and sequences one registered request/ready access
// at a time. A saturating starvation counter lets the debug port win once
// the MEM stage has beaten it STARVE_LIMIT times in a row.
//
// Ports
//   clock, reset           rising-edge clock, async active-low reset
//   mem*                   MEM stage request, held until memStall falls;
//                          memStall/memRData are combinational
//   dbg*                   debug word request, held until dbgDone;
//                          dbgGnt/dbgDone are one-cycle pulses
//   dm*                    registered request to memory, dmRData/dmReady back
module dm_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        memReq,
   input  logic        memWe,
   input  logic [31:0] memAddr,
   input  logic [31:0] memWData,
   input  logic [3:0]  memByteEn,
   output logic [31:0] memRData,
   output logic        memStall,
   input  logic        dbgReq,
   input  logic        dbgWe,
   input  logic [31:0] dbgAddr,
   input  logic [31:0] dbgWData,
   output logic        dbgGnt,
   output logic        dbgDone,
   output logic [31:0] dbgRData,
   output logic        dmReq,
   output logic        dmWe,
   output logic [31:0] dmAddr,
   output logic [31:0] dmWData,
   output logic [3:0]  dmByteEn,
   input  logic [31:0] dmRData,
   input  logic        dmReady
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] BUSY_MEM = 2'd1;
   localparam logic [1:0] BUSY_DBG = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic             grant_mem_c;
   logic             grant_dbg_c;
   logic             starve_inc_c;
   logic             done_c;

   // Word alignment drops the byte offset bits of both requesters.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{memAddr[1:0], dbgAddr[1:0]};

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Arbitration and completion decode
   always_comb begin
      state_nxt    = state;
      grant_mem_c  = 1'b0;
      grant_dbg_c  = 1'b0;
      starve_inc_c = 1'b0;
      done_c       = 1'b0;
      case (state)
         IDLE: begin
            if (dbgReq && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
               grant_dbg_c = 1'b1;
               state_nxt   = BUSY_DBG;
            end else if (memReq) begin
               grant_mem_c  = 1'b1;
               starve_inc_c = dbgReq;
               state_nxt    = BUSY_MEM;
            end else if (dbgReq) begin
               grant_dbg_c = 1'b1;
               state_nxt   = BUSY_DBG;
            end
         end
         BUSY_MEM, BUSY_DBG: begin
            if (dmReady) begin
               done_c    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Memory-side request registers: load at grant, drop strobes at completion
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dmReq    <= 1'b0;
         dmWe     <= 1'b0;
         dmAddr   <= 32'h0;
         dmWData  <= 32'h0;
         dmByteEn <= 4'h0;
      end else if (grant_mem_c) begin
         dmReq    <= 1'b1;
         dmWe     <= memWe;
         dmAddr   <= {memAddr[31:2], 2'b00};
         dmWData  <= memWData;
         dmByteEn <= memByteEn;
      end else if (grant_dbg_c) begin
         dmReq    <= 1'b1;
         dmWe     <= dbgWe;
         dmAddr   <= {dbgAddr[31:2], 2'b00};
         dmWData  <= dbgWData;
         dmByteEn <= 4'b1111;
      end else if (done_c) begin
         dmReq    <= 1'b0;
         dmWe     <= 1'b0;
         dmByteEn <= 4'h0;
      end
   end

   // Debug handshake pulses and captured read data
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dbgGnt   <= 1'b0;
         dbgDone  <= 1'b0;
         dbgRData <= 32'h0;
      end else begin
         dbgGnt  <= grant_dbg_c;
         dbgDone <= done_c && (state == BUSY_DBG);
         if (done_c && (state == BUSY_DBG) && !dmWe) begin
            dbgRData <= dmRData;
         end
      end
   end

   // Starvation counter: counts debug losses, cleared by any debug grant
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (grant_dbg_c) begin
         starve_cnt <= '0;
      end else if (starve_inc_c && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // MEM stage is released in the same cycle its access completes.
   assign memStall = reset & memReq & ~((state == BUSY_MEM) & dmReady);
   assign memRData = dmRData;

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

   typedef struct packed {
      logic        dbg;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } dm_tx_t;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
   } resp_t;

   typedef struct {
      logic [31:0] rdata;
      int          stall;
   } mem_exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        memReq = 1'b0, memWe = 1'b0;
   logic [31:0] memAddr = '0, memWData = '0;
   logic [3:0]  memByteEn = '0;
   logic [31:0] memRData;
   logic        memStall;
   logic        dbgReq = 1'b0, dbgWe = 1'b0;
   logic [31:0] dbgAddr = '0, dbgWData = '0;
   logic        dbgGnt, dbgDone;
   logic [31:0] dbgRData;
   logic        dmReq, dmWe;
   logic [31:0] dmAddr, dmWData;
   logic [3:0]  dmByteEn;
   logic [31:0] dmRData = '0;
   logic        dmReady = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   dm_tx_t      exp_dm_q[$];
   resp_t       resp_q[$];
   mem_exp_t    exp_mem_q[$];
   logic [31:0] exp_dbg_q[$];

   dm_port_arbiter #(.STARVE_LIMIT(2)) dut (
      .clock(clock), .reset(reset),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
      .memByteEn(memByteEn), .memRData(memRData), .memStall(memStall),
      .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWData(dbgWData),
      .dbgGnt(dbgGnt), .dbgDone(dbgDone), .dbgRData(dbgRData),
      .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmWData(dmWData),
      .dmByteEn(dmByteEn), .dmRData(dmRData), .dmReady(dmReady)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory model: each new request pops a latency/read-data entry.
   initial begin
      resp_t cur;
      int    cnt;
      bit    active;
      active = 1'b0;
      cnt    = 0;
      cur    = '{0, 32'hBAD0BAD0};
      forever begin
         @(posedge clock);
         #2;
         if (!reset || !dmReq) begin
            dmReady = 1'b0;
            active  = 1'b0;
         end else begin
            if (!active) begin
               active = 1'b1;
               cnt    = 0;
               if (resp_q.size() != 0) cur = resp_q.pop_front();
               else cur = '{0, 32'hBAD0BAD0};
            end
            dmReady = (cnt == cur.lat);
            dmRData = cur.rdata;
            cnt++;
         end
      end
   end

   // Monitor / scoreboard, sampling on the falling edge.
   initial begin
      dm_tx_t   cur;
      mem_exp_t me;
      bit       prev_req, done_due, rise;
      int       stall_cnt;
      prev_req = 0; done_due = 0; stall_cnt = 0; cur = '0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            prev_req = 0; done_due = 0; stall_cnt = 0; cur = '0;
         end else begin
            rise = dmReq && !prev_req;
            if (dbgDone || done_due) check("dbg_done_timing", 72'(dbgDone), 72'(done_due));
            done_due = 0;
            if (dbgDone) begin
               if (exp_dbg_q.size() == 0) check("dbg_done_unexpected", 72'(1), 72'(0));
               else check("dbg_rdata", 72'(dbgRData), 72'(exp_dbg_q.pop_front()));
            end
            if (dbgGnt && !rise) check("dbg_gnt_spurious", 72'(1), 72'(0));
            if (rise) begin
               if (exp_dm_q.size() == 0) begin
                  check("dm_req_unexpected", 72'(1), 72'(0));
                  cur = '0;
               end else begin
                  cur = exp_dm_q.pop_front();
                  check("dm_issue", 72'({dmWe, dmAddr, dmWData, dmByteEn}),
                        72'({cur.we, cur.addr, cur.wdata, cur.be}));
                  check("dbg_gnt_at_issue", 72'(dbgGnt), 72'(cur.dbg));
               end
            end else if (dmReq) begin
               check("dm_hold", 72'({dmWe, dmAddr, dmWData, dmByteEn}),
                     72'({cur.we, cur.addr, cur.wdata, cur.be}));
            end
            if (dmReq && dmReady && cur.dbg) done_due = 1;
            if (memStall) stall_cnt++;
            if (memReq && !memStall) begin
               if (exp_mem_q.size() == 0) begin
                  check("mem_done_unexpected", 72'(1), 72'(0));
               end else begin
                  me = exp_mem_q.pop_front();
                  check("mem_rdata", 72'(memRData), 72'(me.rdata));
                  check("mem_stall_cycles", 72'(stall_cnt), 72'(me.stall));
               end
               stall_cnt = 0;
            end
            prev_req = dmReq;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_mem_done(input int max, input string name);
      bit seen = 0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clock);
         if (reset && memReq && !memStall) seen = 1;
      end
      if (!seen) check(name, 72'(0), 72'(1));
      #1 memReq = 1'b0;
   endtask

   task automatic wait_dbg_done(input int max, input string name);
      bit seen = 0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clock);
         if (dbgDone) seen = 1;
      end
      if (!seen) check(name, 72'(0), 72'(1));
      #1 dbgReq = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  mem_done;
      bit  seen;

      // Reset with both requesters active: nothing may move.
      reset = 1'b0;
      memReq = 1'b1; memWe = 1'b0; memAddr = 32'h0000_0104; memWData = '0; memByteEn = 4'hF;
      dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 32'h0000_0020; dbgWData = 32'h1234_5678;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_dmReq",    72'(dmReq),    72'(0));
      check("rst_dmWe",     72'(dmWe),     72'(0));
      check("rst_dmAddr",   72'(dmAddr),   72'(0));
      check("rst_dmWData",  72'(dmWData),  72'(0));
      check("rst_dmByteEn", 72'(dmByteEn), 72'(0));
      check("rst_dbgGnt",   72'(dbgGnt),   72'(0));
      check("rst_dbgDone",  72'(dbgDone),  72'(0));
      check("rst_dbgRData", 72'(dbgRData), 72'(0));
      check("rst_memStall", 72'(memStall), 72'(0));

      // Simultaneous requests after release: MEM first, then slow debug write.
      exp_dm_q.push_back('{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'hF});
      resp_q.push_back('{0, 32'h00C0_FFEE});
      exp_mem_q.push_back('{32'h00C0_FFEE, 1});
      exp_dm_q.push_back('{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF});
      resp_q.push_back('{3, 32'h7777_7777});
      exp_dbg_q.push_back(32'h0);
      tick();
      reset = 1'b1;
      wait_mem_done(10, "t1_mem_timeout");
      wait_dbg_done(20, "t1_dbg_timeout");
      repeat (2) tick();

      // MEM load, immediate ready, unaligned address.
      exp_dm_q.push_back('{1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'b1000});
      resp_q.push_back('{0, 32'hDEAD_BEEF});
      exp_mem_q.push_back('{32'hDEAD_BEEF, 1});
      memReq = 1'b1; memWe = 1'b0; memAddr = 32'h0000_1003; memWData = '0; memByteEn = 4'b1000;
      wait_mem_done(10, "t2_mem_timeout");
      repeat (2) tick();

      // MEM byte write, one wait state.
      exp_dm_q.push_back('{1'b0, 1'b1, 32'h0000_0204, 32'h00AB_0000, 4'b0100});
      resp_q.push_back('{1, 32'h0});
      exp_mem_q.push_back('{32'h0, 2});
      memReq = 1'b1; memWe = 1'b1; memAddr = 32'h0000_0206; memWData = 32'h00AB_0000; memByteEn = 4'b0100;
      wait_mem_done(10, "t3_mem_timeout");
      memWe = 1'b0;
      repeat (2) tick();

      // Starvation: MEM held continuously, debug wins the third arbitration.
      for (int i = 0; i < 4; i++) resp_q.push_back('{0, 32'h5A5A_0001});
      exp_dm_q.push_back('{1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'hF});
      exp_dm_q.push_back('{1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'hF});
      exp_dm_q.push_back('{1'b1, 1'b0, 32'h0000_0088, 32'h0, 4'hF});
      exp_dm_q.push_back('{1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'hF});
      exp_mem_q.push_back('{32'h5A5A_0001, 1});
      exp_mem_q.push_back('{32'h5A5A_0001, 1});
      exp_mem_q.push_back('{32'h5A5A_0001, 3});
      exp_dbg_q.push_back(32'h5A5A_0001);
      memReq = 1'b1; memAddr = 32'h0000_3000; memWData = '0; memByteEn = 4'hF;
      dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 32'h0000_0088; dbgWData = '0;
      mem_done = 0;
      for (int i = 0; i < 40 && mem_done < 3; i++) begin
         @(negedge clock);
         if (memReq && !memStall) mem_done++;
         if (dbgDone) #1 dbgReq = 1'b0;
         else if (mem_done == 3) #1 memReq = 1'b0;
      end
      #1 memReq = 1'b0;
      check("t4_mem_completions", 72'(mem_done), 72'(3));
      repeat (2) tick();

      // Reset in the middle of a debug access: abandoned, no dbgDone.
      exp_dm_q.push_back('{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF});
      resp_q.push_back('{5, 32'h1111_1111});
      dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 32'h0000_0040; dbgWData = '0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clock);
         if (dmReq) seen = 1;
      end
      if (!seen) check("t5_grant_timeout", 72'(0), 72'(1));
      repeat (2) tick();
      reset = 1'b0;
      dbgReq = 1'b0;
      #1;
      check("t5_async_dmReq", 72'(dmReq), 72'(0));
      check("t5_async_dbgGnt", 72'(dbgGnt), 72'(0));
      repeat (2) tick();
      reset = 1'b1;
      repeat (6) tick();

      // Normal debug read afterwards.
      exp_dm_q.push_back('{1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'hF});
      resp_q.push_back('{2, 32'hCAFE_F00D});
      exp_dbg_q.push_back(32'hCAFE_F00D);
      dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 32'h0000_0047; dbgWData = '0;
      wait_dbg_done(20, "t5_dbg_timeout");
      repeat (3) tick();

      check("end_dm_queue",  72'(exp_dm_q.size()),  72'(0));
      check("end_mem_queue", 72'(exp_mem_q.size()), 72'(0));
      check("end_dbg_queue", 72'(exp_dbg_q.size()), 72'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
